// File: rtl/rca_seq_ctrl.sv
// Multi-cycle adder: a WIDTH-bit add performed one SLICE-bit ripple slice per cycle,
// with valid/ready handshakes on both the operand and result sides.
module rca_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("rca_seq_ctrl: WIDTH must be an integer multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE:0]   slice_sum;
    int               slice_lo;

    // The single shared slice adder, fed from the slice selected by k.
    always_comb begin
        slice_lo  = int'(k) * SLICE;
        a_slice   = a_reg[slice_lo +: SLICE];
        b_slice   = b_reg[slice_lo +: SLICE];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry};
    end

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        k     <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[slice_lo +: SLICE] <= slice_sum[SLICE-1:0];
                    carry                  <= slice_sum[SLICE];
                    // The last slice holds the MSB, so the overflow check can use it directly.
                    if (k == K_LAST) begin
                        cout      <= slice_sum[SLICE];
                        ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (slice_sum[SLICE-1] != a_reg[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed vector table, backpressure and reset
// sequences, and a randomized sweep across four slice widths against an arithmetic model.
module tb_rca_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_ready;

    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  co;
    logic [3:0]  of;
    logic [3:0]  bz;
    logic [31:0] sm [4];

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [7];
    int   lat_exp [4];

    // Instance 0 (SLICE=8) is the main device; the others only take part in the sweep.
    rca_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]), .cout(co[0]), .ovf(of[0]), .busy(bz[0])
    );
    rca_seq_ctrl #(.WIDTH(32), .SLICE(32)) dut_s32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .cout(co[1]), .ovf(of[1]), .busy(bz[1])
    );
    rca_seq_ctrl #(.WIDTH(32), .SLICE(16)) dut_s16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .cout(co[2]), .ovf(of[2]), .busy(bz[2])
    );
    rca_seq_ctrl #(.WIDTH(32), .SLICE(4)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[3]), .out_ready(out_ready), .sum(sm[3]), .cout(co[3]), .ovf(of[3]), .busy(bz[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain wide arithmetic, overflow as "signed result out of 32-bit range".
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic c,
                                  output logic [31:0] s, output logic co_m, output logic ov_m);
        logic [63:0] u;
        longint      sg;
        u    = {32'b0, x} + {32'b0, y} + 64'(c);
        s    = u[31:0];
        co_m = u[32];
        sg   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        ov_m = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
    endfunction

    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic c);
        @(negedge clk);
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
    endtask

    // Wait (bounded) for the main device's out_valid; returns cycles counted after the accepting edge.
    task automatic waitValid(output int n);
        n = 0;
        while (ov[0] !== 1'b1 && n < 20) begin
            checkOutput("in_ready_while_busy", ir[0], 1'b0);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic doOp(input logic [31:0] x, input logic [31:0] y, input logic c,
                        input logic [31:0] es, input logic ec, input logic eo);
        int n;
        out_ready = 1'b1;
        applyStimulus(x, y, c);
        checkOutput("in_ready_idle", ir[0], 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("busy_after_accept", bz[0], 1'b1);
        waitValid(n);
        checkOutput("latency", n, 4);
        checkOutput("sum", sm[0], es);
        checkOutput("cout", co[0], ec);
        checkOutput("ovf", of[0], eo);
        @(posedge clk);
        #1;
        checkOutput("out_valid_after_handshake", ov[0], 1'b0);
        checkOutput("busy_after_handshake", bz[0], 1'b0);
        checkOutput("sum_held_in_idle", sm[0], es);
    endtask

    task automatic sweepOp(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [31:0] es;
        logic        ec;
        logic        eo;
        int          lat [4];
        model(x, y, c, es, ec, eo);
        out_ready = 1'b1;
        applyStimulus(x, y, c);
        checkOutput("sweep_in_ready", ir, 4'hF);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = '{-1, -1, -1, -1};
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && lat[i] < 0) begin
                    lat[i] = cyc;
                    checkOutput($sformatf("sweep_sum[%0d]", i), sm[i], es);
                    checkOutput($sformatf("sweep_cout[%0d]", i), co[i], ec);
                    checkOutput($sformatf("sweep_ovf[%0d]", i), of[i], eo);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("sweep_latency[%0d]", i), lat[i], lat_exp[i]);
        end
    endtask

    initial begin
        int          n;
        logic [31:0] x;
        logic [31:0] y;

        total = 0;
        bad   = 0;
        lat_exp = '{4, 1, 2, 8};

        vecs[0] = '{32'h0000000A, 32'h00000009, 1'b0, 32'h00000013, 1'b0, 1'b0};
        vecs[1] = '{32'h0000024A, 32'h0000012A, 1'b0, 32'h00000374, 1'b0, 1'b0};
        vecs[2] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[5] = '{32'h00FFFF00, 32'h0000FF00, 1'b1, 32'h0100FE01, 1'b0, 1'b0};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;

        #3;
        checkOutput("reset_in_ready", ir[0], 1'b0);
        checkOutput("reset_out_valid", ov[0], 1'b0);
        checkOutput("reset_busy", bz[0], 1'b0);
        checkOutput("reset_sum", sm[0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_reset", ir[0], 1'b1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 7; i++) begin
            doOp(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        $display("[TB] backpressure sequence");
        out_ready = 1'b0;
        applyStimulus(32'h11111111, 32'h22222222, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitValid(n);
        checkOutput("bp_latency", n, 4);
        applyStimulus(32'h0000024A, 32'h0000012A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid_held", ov[0], 1'b1);
            checkOutput("bp_sum_held", sm[0], 32'h33333333);
            checkOutput("bp_cout_held", co[0], 1'b0);
            checkOutput("bp_ovf_held", of[0], 1'b0);
            checkOutput("bp_in_ready_low", ir[0], 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_out_valid_dropped", ov[0], 1'b0);
        checkOutput("bp_in_ready_back", ir[0], 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_next_accepted", bz[0], 1'b1);
        waitValid(n);
        checkOutput("bp_next_latency", n, 4);
        checkOutput("bp_next_sum", sm[0], 32'h00000374);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-operation");
        doOp(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        applyStimulus(32'hDEADBEEF, 32'h12345678, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", ov[0], 1'b0);
        checkOutput("midrst_busy", bz[0], 1'b0);
        checkOutput("midrst_sum", sm[0], 32'h0);
        checkOutput("midrst_cout", co[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        doOp(32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0);

        $display("[TB] randomized sweep over slice widths");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: x = 32'h7FFFFFFF;
                1: y = 32'h80000000;
                2: begin x = 32'hFFFFFFFF; y = 32'h00000000; end
                default: ;
            endcase
            sweepOp(x, y, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
